// File: rtl/seq_counter_pkg.sv
// -----------------------------------------------------------------------------
// seq_counter_pkg
// Shared defaults and helpers for the table-driven sequence counter.
//   DEF_WIDTH      default counter state width
//   DEF_START_VAL  default reset / restart value
//   DEF_CNT_W      default step counter width
//   default_next() reset contents of the next-state table (binary up-count)
// -----------------------------------------------------------------------------
package seq_counter_pkg;

    localparam int DEF_WIDTH     = 4;
    localparam int DEF_START_VAL = 0;
    localparam int DEF_CNT_W     = 8;

    // Successor of entry i in a plain binary up-count of the given width.
    function automatic int unsigned default_next(input int unsigned width,
                                                 input int unsigned i);
        return (i + 32'd1) % (32'd1 << width);
    endfunction

endpackage

// File: rtl/seq_next_table.sv
// -----------------------------------------------------------------------------
// seq_next_table
// 2**WIDTH x WIDTH next-state register file.
//   clk          clock, rising edge
//   rst          synchronous active-low reset; entries return to default_next
//   wr_en        write strobe
//   wr_addr      write index
//   wr_data      write value
//   lookup_addr  asynchronous read index (current counter state)
//   lookup_data  table[lookup_addr], combinational
//   rd_addr      readback index
//   rd_data      table[rd_addr], registered (old value on same-cycle write)
// -----------------------------------------------------------------------------
module seq_next_table
    import seq_counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [WIDTH-1:0] lookup_addr,
    output logic [WIDTH-1:0] lookup_data,
    input  logic [WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    localparam int DEPTH = 2 ** WIDTH;

    logic [WIDTH-1:0] table_r   [DEPTH];
    logic [WIDTH-1:0] rst_val_s [DEPTH];
    logic [WIDTH-1:0] rd_data_r;

    // Constant reset image of the table, one binary successor per entry.
    for (genvar g = 0; g < DEPTH; g++) begin : g_rst_val
        localparam logic [31:0] RST_FULL = 32'(default_next(WIDTH, g));
        assign rst_val_s[g] = RST_FULL[WIDTH-1:0];
    end

    // Table storage: reset discards any concurrent write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_r[i] <= rst_val_s[i];
            end
        end else if (wr_en) begin
            table_r[wr_addr] <= wr_data;
        end
    end

    // Registered readback port; samples the pre-write contents.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data_r <= {WIDTH{1'b0}};
        end else begin
            rd_data_r <= table_r[rd_addr];
        end
    end

    // Lookup sees the stored (old) entry, giving read-before-write for q.
    assign lookup_data = table_r[lookup_addr];
    assign rd_data     = rd_data_r;

endmodule

// File: rtl/seq_table_counter.sv
// -----------------------------------------------------------------------------
// seq_table_counter
// Fully synchronous sequence counter whose successor function is a
// run-time programmable next-state table.
//   clk       clock, rising edge
//   rst       synchronous active-low reset
//   en        advance q to table[q]
//   load      force q to load_val (wins over en)
//   load_val  value for load
//   wr_en     table write strobe
//   wr_addr   table write index
//   wr_data   table write value
//   rd_addr   table readback index
//   rd_data   table[rd_addr], registered, 1-cycle latency
//   q         current state, registered
//   restart   1-cycle registered pulse when q becomes START_VAL by en or load
//   step_cnt  saturating count of advances since last restart
// -----------------------------------------------------------------------------
module seq_table_counter
    import seq_counter_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int START_VAL = DEF_START_VAL,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] q,
    output logic             restart,
    output logic [CNT_W-1:0] step_cnt
);

    localparam logic [WIDTH-1:0] START_Q  = WIDTH'(START_VAL);
    localparam logic [CNT_W-1:0] STEP_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] STEP_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_r;
    logic             restart_r;
    logic [CNT_W-1:0] step_cnt_r;

    logic [WIDTH-1:0] table_next_s;
    logic [WIDTH-1:0] q_next_s;
    logic             restart_next_s;
    logic [CNT_W-1:0] step_next_s;

    seq_next_table #(
        .WIDTH (WIDTH)
    ) u_table (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .lookup_addr (q_r),
        .lookup_data (table_next_s),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    // Next-state selection: load over en over hold.
    always_comb begin
        q_next_s       = q_r;
        restart_next_s = 1'b0;
        step_next_s    = step_cnt_r;
        if (load) begin
            q_next_s       = load_val;
            restart_next_s = (load_val == START_Q);
            step_next_s    = {CNT_W{1'b0}};
        end else if (en) begin
            q_next_s = table_next_s;
            if (table_next_s == START_Q) begin
                restart_next_s = 1'b1;
                step_next_s    = {CNT_W{1'b0}};
            end else if (step_cnt_r == STEP_MAX) begin
                // Saturate rather than wrap so long runs stay distinguishable.
                step_next_s = STEP_MAX;
            end else begin
                step_next_s = step_cnt_r + STEP_ONE;
            end
        end else begin
            q_next_s       = q_r;
            restart_next_s = 1'b0;
            step_next_s    = step_cnt_r;
        end
    end

    // Counter state registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q_r        <= START_Q;
            restart_r  <= 1'b0;
            step_cnt_r <= {CNT_W{1'b0}};
        end else begin
            q_r        <= q_next_s;
            restart_r  <= restart_next_s;
            step_cnt_r <= step_next_s;
        end
    end

    assign q        = q_r;
    assign restart  = restart_r;
    assign step_cnt = step_cnt_r;

endmodule

// File: tb/tb_seq_table_counter.sv
module tb_seq_table_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       load;
    logic [3:0] load_val;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [3:0] wr_data;
    logic [3:0] rd_addr;
    logic [3:0] rd_data;
    logic [3:0] q;
    logic       restart;
    logic [7:0] step_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic       load;
        logic [3:0] load_val;
        logic       wr_en;
        logic [3:0] wr_addr;
        logic [3:0] wr_data;
        logic [3:0] rd_addr;
        logic       chk_rd;
        logic [3:0] exp_q;
        logic       exp_restart;
        logic [7:0] exp_step;
        logic [3:0] exp_rd;
    } vec_t;

    vec_t vecs[$];

    seq_table_counter dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .q        (q),
        .restart  (restart),
        .step_cnt (step_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic e, input logic l,
                       input logic [3:0] lv, input logic we,
                       input logic [3:0] wa, input logic [3:0] wd,
                       input logic [3:0] ra, input logic ck,
                       input logic [3:0] eq, input logic er,
                       input logic [7:0] es, input logic [3:0] erd);
        vec_t v;
        v.rst = r; v.en = e; v.load = l; v.load_val = lv;
        v.wr_en = we; v.wr_addr = wa; v.wr_data = wd; v.rd_addr = ra;
        v.chk_rd = ck; v.exp_q = eq; v.exp_restart = er;
        v.exp_step = es; v.exp_rd = erd;
        vecs.push_back(v);
    endtask

    task automatic check(input int idx, input string name,
                         input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL vec %0d %s actual=%0d required=%0d", idx, name, act, exp);
        end
    endtask

    initial begin
        logic [3:0] pa [8];
        logic [3:0] pd [8];
        logic [3:0] head [3];
        logic [3:0] cyc [4];
        logic [3:0] eq;

        pa = '{4'd0, 4'd2, 4'd5, 4'd7, 4'd8, 4'd10, 4'd9, 4'd11};
        pd = '{4'd2, 4'd5, 4'd7, 4'd8, 4'd10, 4'd9, 4'd11, 4'd8};
        head = '{4'd2, 4'd5, 4'd7};
        cyc  = '{4'd8, 4'd10, 4'd9, 4'd11};

        // Reset: everything cleared, rd_data zero.
        add(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 4'd0, 1'b0, 8'd0, 4'd0);
        // Default table: 17 advances, wrap to 0 with restart, readback k+1.
        for (int k = 1; k <= 17; k++) begin
            add(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 4'(k), 1'b1,
                4'(k % 16), (k == 16), 8'(k % 16), 4'((k + 1) % 16));
        end
        // Program the custom sequence while holding at q=1, step=1.
        for (int i = 0; i < 8; i++) begin
            add(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, pa[i], pd[i], 4'd0, 1'b1,
                4'd1, 1'b0, 8'd1, (i == 0) ? 4'd1 : 4'd2);
        end
        // Load start value: restart pulse, step cleared.
        add(1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 4'd0, 1'b1, 8'd0, 4'd2);
        // Walk the custom sequence until step saturates; end on q=10.
        for (int k = 1; k <= 261; k++) begin
            eq = (k <= 3) ? head[k - 1] : cyc[(k - 4) % 4];
            add(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0,
                eq, 1'b0, (k > 255) ? 8'd255 : 8'(k), 4'd0);
        end
        // Reset with concurrent write to entry 5: write discarded.
        add(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 4'd5, 4'd3, 4'd5, 1'b1, 4'd0, 1'b0, 8'd0, 4'd0);
        add(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd5, 1'b1, 4'd0, 1'b0, 8'd0, 4'd6);
        add(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 4'd0, 1'b0, 8'd0, 4'd1);
        // Load beats en; loading START_VAL pulses restart exactly once.
        add(1'b1, 1'b1, 1'b1, 4'd9, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd9, 1'b0, 8'd0, 4'd0);
        add(1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1, 8'd0, 4'd0);
        add(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 8'd0, 4'd0);
        // Read-before-write on the current entry.
        add(1'b1, 1'b0, 1'b1, 4'd3, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd3, 1'b0, 8'd0, 4'd0);
        add(1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 4'd3, 4'd12, 4'd3, 1'b1, 4'd4, 1'b0, 8'd1, 4'd4);
        add(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd3, 1'b1, 4'd4, 1'b0, 8'd1, 4'd12);
        add(1'b1, 1'b0, 1'b1, 4'd3, 1'b0, 4'd0, 4'd0, 4'd3, 1'b1, 4'd3, 1'b0, 8'd0, 4'd12);
        add(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd3, 1'b1, 4'd12, 1'b0, 8'd1, 4'd12);
        // Self-loop on 6: q holds, step climbs, no restart.
        add(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd6, 4'd6, 4'd6, 1'b1, 4'd12, 1'b0, 8'd1, 4'd7);
        add(1'b1, 1'b0, 1'b1, 4'd6, 1'b0, 4'd0, 4'd0, 4'd6, 1'b1, 4'd6, 1'b0, 8'd0, 4'd6);
        for (int k = 1; k <= 4; k++) begin
            add(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd6, 1'b1,
                4'd6, 1'b0, 8'(k), 4'd6);
        end

        rst = 1'b0; en = 1'b0; load = 1'b0; load_val = 4'd0;
        wr_en = 1'b0; wr_addr = 4'd0; wr_data = 4'd0; rd_addr = 4'd0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst      = vecs[i].rst;
            en       = vecs[i].en;
            load     = vecs[i].load;
            load_val = vecs[i].load_val;
            wr_en    = vecs[i].wr_en;
            wr_addr  = vecs[i].wr_addr;
            wr_data  = vecs[i].wr_data;
            rd_addr  = vecs[i].rd_addr;
            @(posedge clk);
            #1;
            check(i, "q", {4'd0, q}, {4'd0, vecs[i].exp_q});
            check(i, "restart", {7'd0, restart}, {7'd0, vecs[i].exp_restart});
            check(i, "step_cnt", step_cnt, vecs[i].exp_step);
            if (vecs[i].chk_rd) begin
                check(i, "rd_data", {4'd0, rd_data}, {4'd0, vecs[i].exp_rd});
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
